// File: rtl/lif_pkg.sv
// Shared constants for the LIF neuron datapath.
// Widths, synaptic integrator states and saturation bounds.
package lif_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int dp_w(input int n_stage);
    return n_stage + 2;
  endfunction

  function automatic int acc_w(input int w, input int n);
    return w + $clog2(n);
  endfunction

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/syn_weight_regfile.sv
// Synaptic weight storage: one write port,
// one combinational read port.
module syn_weight_regfile #(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [N-1:0][W-1:0] mem_q;
  logic [N-1:0][W-1:0] mem_d;

  // next weight array: write lands at the edge
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // weight flops, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/syn_weighted_sum.sv
// Sequential synaptic integrator: sum of w[i]*x[i],
// one input per clock, saturated to the datapath width.
module syn_weighted_sum
  import lif_pkg::*;
#(
  parameter int n_stage  = 6,
  parameter int N_INPUTS = 8,
  localparam int W  = dp_w(n_stage),
  localparam int IW = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] x_spikes,
  input  logic                start,
  input  logic                w_we,
  input  logic [IW-1:0]       w_addr,
  input  logic [W-1:0]        w_data,
  output logic                busy,
  output logic                sum_valid,
  output logic [W-1:0]        sum_wx
);

  localparam int AW = acc_w(W, N_INPUTS);
  localparam logic signed [AW-1:0] HI = AW'(sat_hi(W));
  localparam logic signed [AW-1:0] LO = AW'(sat_lo(W));

  logic [1:0]               state_q, state_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [N_INPUTS-1:0]      x_q, x_d;
  logic [W-1:0]             sum_q, sum_d;
  logic                     valid_q, valid_d;
  logic [W-1:0]             w_rd;
  logic signed [AW-1:0]     w_ext;

  syn_weight_regfile #(
    .W (W),
    .N (N_INPUTS),
    .AW(IW)
  ) u_wrf (
    .clk  (clk),
    .rst  (rst),
    .we   (w_we),
    .waddr(w_addr),
    .wdata(w_data),
    .raddr(idx_q),
    .rdata(w_rd)
  );

  assign w_ext = {{(AW-W){w_rd[W-1]}}, w_rd};

  // sequencer: latch spikes, accumulate one weight per clock, saturate
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    x_d     = x_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          x_d     = x_spikes;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        if (x_q[idx_q]) acc_d = acc_q + w_ext;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(N_INPUTS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (acc_q > HI)      sum_d = HI[W-1:0];
        else if (acc_q < LO) sum_d = LO[W-1:0];
        else                 sum_d = acc_q[W-1:0];
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // integrator state; reset aborts any integration in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign sum_valid = valid_q;
  assign sum_wx    = sum_q;

endmodule
